// File: rtl/ternary_regdump_if.sv
// Trit type shared by the register dump engine and its sinks, plus the serial
// trit stream interface (valid/ready handshake with register and end markers).
package ternary_regdump_pkg;
  typedef enum logic [1:0] {
    T_ZERO = 2'b00,
    T_POS  = 2'b01,
    T_NEG  = 2'b10
  } trit_t;
endpackage

interface ternary_regdump_if;
  import ternary_regdump_pkg::*;

  trit_t       out_trit;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_reg_idx;
  logic        out_last_trit;
  logic        out_last;

  modport master (
    output out_trit, out_valid, out_reg_idx, out_last_trit, out_last,
    input  out_ready
  );

  modport slave (
    input  out_trit, out_valid, out_reg_idx, out_last_trit, out_last,
    output out_ready
  );
endinterface

// File: rtl/ternary_regdump.sv
// Serial dump of a ternary register file, one trit per handshake, MSB first.
// Optional REGDUMP_SKIP_R0_EN starts the scan at R1 (R0 is hardwired zero).
module ternary_regdump
  import ternary_regdump_pkg::*;
#(
  parameter int NUM_REGS   = 9,
  parameter int TRIT_WIDTH = 27
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic [3:0]              dbg_reg_idx,
  input  trit_t [TRIT_WIDTH-1:0]  dbg_reg_data,
  ternary_regdump_if.master       bus,
  output logic                    busy,
  output logic                    done
);

  localparam int TCW = (TRIT_WIDTH > 1) ? $clog2(TRIT_WIDTH) : 1;
  localparam logic [TCW-1:0] TRIT_TOP = TCW'(TRIT_WIDTH - 1);
  localparam logic [TCW-1:0] TRIT_ONE = TCW'(1);
  localparam logic [3:0]     LAST_IDX = 4'(NUM_REGS - 1);
`ifdef REGDUMP_SKIP_R0_EN
  localparam logic [3:0]     FIRST_IDX = 4'd1;
`else
  localparam logic [3:0]     FIRST_IDX = 4'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_reg_cnt;
  logic [TCW-1:0]         r_trit_cnt;
  trit_t [TRIT_WIDTH-1:0] r_shadow;
  trit_t                  r_out_trit;
  logic                   r_out_valid;
  logic [3:0]             r_out_reg_idx;
  logic                   r_out_last_trit;
  logic                   r_out_last;
  logic                   r_busy;
  logic                   r_done;

  // The register counter only moves when entering LOAD, so it doubles as the
  // debug index and naturally holds its value in every other state.
  assign dbg_reg_idx       = r_reg_cnt;
  assign bus.out_trit      = r_out_trit;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_reg_idx   = r_out_reg_idx;
  assign bus.out_last_trit = r_out_last_trit;
  assign bus.out_last      = r_out_last;
  assign busy              = r_busy;
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign done              = r_done & ~abort;

  // NOTE: every register here is assigned with <= so all next-state values are
  // computed from the same pre-edge snapshot, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_reg_cnt       <= 4'd0;
      r_trit_cnt      <= '0;
      // NOTE: the shadow array is explicitly reset so a dump aborted by reset
      // can never leak stale register contents into a later observation.
      for (int i = 0; i < TRIT_WIDTH; i++) r_shadow[i] <= T_ZERO;
      r_out_trit      <= T_ZERO;
      r_out_valid     <= 1'b0;
      r_out_reg_idx   <= 4'd0;
      r_out_last_trit <= 1'b0;
      r_out_last      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else if (abort && (r_state != S_IDLE)) begin
      r_state         <= S_IDLE;
      r_out_trit      <= T_ZERO;
      r_out_valid     <= 1'b0;
      r_out_last_trit <= 1'b0;
      r_out_last      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state    <= S_LOAD;
            r_reg_cnt  <= FIRST_IDX;
            r_trit_cnt <= TRIT_TOP;
            r_busy     <= 1'b1;
          end
        end

        S_LOAD: begin
          r_shadow        <= dbg_reg_data;
          r_out_trit      <= dbg_reg_data[TRIT_WIDTH-1];
          r_out_valid     <= 1'b1;
          r_out_reg_idx   <= r_reg_cnt;
          r_out_last_trit <= (TRIT_WIDTH == 1);
          r_out_last      <= (TRIT_WIDTH == 1) && (r_reg_cnt == LAST_IDX);
          r_state         <= S_SHIFT;
        end

        S_SHIFT: begin
          if (bus.out_ready) begin
            if (r_trit_cnt != '0) begin
              r_trit_cnt      <= r_trit_cnt - TRIT_ONE;
              r_out_trit      <= r_shadow[r_trit_cnt - TRIT_ONE];
              r_out_last_trit <= (r_trit_cnt == TRIT_ONE);
              r_out_last      <= (r_trit_cnt == TRIT_ONE) && (r_reg_cnt == LAST_IDX);
            end else begin
              r_out_trit      <= T_ZERO;
              r_out_valid     <= 1'b0;
              r_out_last_trit <= 1'b0;
              r_out_last      <= 1'b0;
              if (r_reg_cnt == LAST_IDX) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_reg_cnt  <= r_reg_cnt + 4'd1;
                r_trit_cnt <= TRIT_TOP;
                r_state    <= S_LOAD;
              end
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_regdump.sv
// Randomized self-checking bench for ternary_regdump: a register-file model,
// a balanced-ternary reference stream, and per-scenario tasks.
module tb_ternary_regdump;
  import ternary_regdump_pkg::*;

  localparam int NUM_REGS = 9;
  localparam int TW       = 27;
`ifdef REGDUMP_SKIP_R0_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int TOTAL  = (NUM_REGS - FIRST) * TW;
  localparam int BUDGET = TOTAL * 4 + NUM_REGS * 4 + 40;

  typedef trit_t [TW-1:0] word_t;
  typedef struct {
    trit_t      t;
    logic [3:0] idx;
    logic       lt;
    logic       l;
  } item_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] dbg_reg_idx;
  word_t      dbg_reg_data;
  logic       busy;
  logic       done;

  word_t  regs [NUM_REGS];
  item_t  exp_q [$];
  longint cap_val [16];
  int     errors = 0;
  int     checks = 0;

  ternary_regdump_if bus ();

  ternary_regdump #(.NUM_REGS(NUM_REGS), .TRIT_WIDTH(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .dbg_reg_idx  (dbg_reg_idx),
    .dbg_reg_data (dbg_reg_data),
    .bus          (bus.master),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always_comb dbg_reg_data = regs[int'(dbg_reg_idx) % NUM_REGS];

  function automatic word_t to_trits(input int value);
    word_t w;
    int    v;
    int    r;
    v = value;
    for (int k = 0; k < TW; k++) begin
      r = ((v % 3) + 3) % 3;
      if (r == 0) begin w[k] = T_ZERO; v = v / 3; end
      else if (r == 1) begin w[k] = T_POS; v = (v - 1) / 3; end
      else begin w[k] = T_NEG; v = (v + 1) / 3; end
    end
    return w;
  endfunction

  function automatic int tval(input trit_t t);
    return (t == T_POS) ? 1 : (t == T_NEG) ? -1 : 0;
  endfunction

  task automatic clear_regs();
    for (int r = 0; r < NUM_REGS; r++) regs[r] = to_trits(0);
  endtask

  task automatic fill_random();
    regs[0] = to_trits(0);
    for (int r = 1; r < NUM_REGS; r++)
      for (int k = 0; k < TW; k++) regs[r][k] = trit_t'($urandom_range(0, 2));
  endtask

  // Expected dump: every scanned register, most significant trit first.
  task automatic build_expected();
    item_t it;
    exp_q.delete();
    for (int r = FIRST; r < NUM_REGS; r++)
      for (int k = TW - 1; k >= 0; k--) begin
        it.t   = regs[r][k];
        it.idx = 4'(r);
        it.lt  = (k == 0);
        it.l   = (k == 0) && (r == NUM_REGS - 1);
        exp_q.push_back(it);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({bus.out_valid, bus.out_trit, bus.out_reg_idx, bus.out_last_trit, bus.out_last,
         dbg_reg_idx, busy, done} !== {1'b0, T_ZERO, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: valid=%b trit=%b ridx=%0d lt=%b l=%b didx=%0d busy=%b done=%b, required all zero",
               tag, bus.out_valid, bus.out_trit, bus.out_reg_idx, bus.out_last_trit,
               bus.out_last, dbg_reg_idx, busy, done);
    end
  endtask

  // Drives one dump from a start pulse and scores the stream against exp_q.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_stream(input int ready_mode, input int restart_reg, input int abort_at,
                            input bit write_r2, input int reset_reg,
                            output int n_xfer, output int n_done, output int first_valid);
    int    cyc;
    bit    prev_stall, last_prev, r2_written, stop, aborted;
    logic  rdy;
    item_t held, e;
    n_xfer = 0; n_done = 0; first_valid = -1;
    prev_stall = 0; last_prev = 0; r2_written = 0; stop = 0; aborted = 0;
    build_expected();
    for (int i = 0; i < 16; i++) cap_val[i] = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_cycle: valid=%b busy=%b, required valid=0 busy=1", bus.out_valid, busy);
    end
    cyc = 0;
    while (!stop) begin
      if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (bus.out_valid !== 1'b1) begin
        checks++;
        if (bus.out_trit !== T_ZERO) begin
          errors++;
          $display("FAIL idle_trit: trit=%b while invalid, required %b", bus.out_trit, T_ZERO);
        end
      end
      if (prev_stall) begin
        checks++;
        if ({bus.out_valid, bus.out_trit, bus.out_reg_idx, bus.out_last_trit, bus.out_last} !==
            {1'b1, held.t, held.idx, held.lt, held.l}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b t=%b idx=%0d lt=%b l=%b, required v=1 t=%b idx=%0d lt=%b l=%b",
                   bus.out_valid, bus.out_trit, bus.out_reg_idx, bus.out_last_trit, bus.out_last,
                   held.t, held.idx, held.lt, held.l);
        end
      end
      if (aborted) begin
        checks++;
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL abort_idle: busy=%b valid=%b done=%b, required 0 0 0", busy, bus.out_valid, done);
        end
      end
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (!last_prev) begin
          errors++;
          $display("FAIL done_timing: done=1 not one cycle after final transfer, required after out_last");
        end
      end
      if (busy !== 1'b1) stop = 1;

      if (!stop && reset_reg >= 0 && bus.out_valid === 1'b1 &&
          int'(bus.out_reg_idx) == reset_reg && (n_xfer % TW) == 10) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
          @(posedge clk); #1;
          checks++;
          if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_resume: busy=%b valid=%b, required 0 0", busy, bus.out_valid);
          end
        end
        stop = 1;
      end

      if (!stop) begin
        case (ready_mode)
          0:       rdy = 1'b1;
          1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (abort_at > 0 && bus.out_valid === 1'b1 && n_xfer == abort_at - 1) begin
          rdy = 1'b1;
          abort = 1'b1;
          aborted = 1;
        end
        if (restart_reg >= 0 && bus.out_valid === 1'b1 && int'(bus.out_reg_idx) == restart_reg)
          start = 1'b1;
        if (write_r2 && !r2_written && bus.out_valid === 1'b1 && bus.out_reg_idx == 4'd2) begin
          regs[2] = to_trits(-1);
          r2_written = 1;
        end
        bus.out_ready = rdy;
        last_prev = 0;
        if (bus.out_valid === 1'b1 && rdy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_xfer: transfer %0d beyond expected %0d", n_xfer + 1, TOTAL);
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_trit, bus.out_reg_idx, bus.out_last_trit, bus.out_last} !==
                {e.t, e.idx, e.lt, e.l}) begin
              errors++;
              $display("FAIL xfer_%0d: got t=%b idx=%0d lt=%b l=%b, required t=%b idx=%0d lt=%b l=%b",
                       n_xfer + 1, bus.out_trit, bus.out_reg_idx, bus.out_last_trit, bus.out_last,
                       e.t, e.idx, e.lt, e.l);
            end
          end
          cap_val[bus.out_reg_idx] = cap_val[bus.out_reg_idx] * 3 + longint'(tval(bus.out_trit));
          n_xfer++;
          last_prev = bus.out_last;
        end
        prev_stall = (bus.out_valid === 1'b1) && !rdy;
        held.t = bus.out_trit; held.idx = bus.out_reg_idx;
        held.lt = bus.out_last_trit; held.l = bus.out_last;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        cyc++;
        if (cyc > BUDGET) begin
          errors++; checks++;
          $display("FAIL timeout: dump still busy after %0d cycles", cyc);
          stop = 1;
        end
      end
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic check_full(input string tag, input int n_xfer, input int n_done);
    checks++;
    if (n_xfer != TOTAL || n_done != 1) begin
      errors++;
      $display("FAIL %s: transfers=%0d done_pulses=%0d, required %0d and 1", tag, n_xfer, n_done, TOTAL);
    end
  endtask

  task automatic test_reset();
    clear_regs();
    bus.out_ready = 1'b1;
    #3 check_reset_outputs("reset_values");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_release");
  endtask

  task automatic test_start_abort_ignored();
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL start_with_abort: busy=%b valid=%b, required 0 0", busy, bus.out_valid);
      end
    end
  endtask

  task automatic test_r1_plus5();
    int nx, nd, fv;
    clear_regs();
    regs[1] = to_trits(5);
    run_stream(0, -1, 0, 0, -1, nx, nd, fv);
    check_full("r1_plus5_count", nx, nd);
    checks++;
    if (fv != 1) begin
      errors++;
      $display("FAIL first_valid_latency: valid after %0d extra cycles, required 1 (2 after start)", fv);
    end
    checks++;
    if (cap_val[1] != 64'sd5) begin
      errors++;
      $display("FAIL r1_value: streamed R1 decodes to %0d, required 5", cap_val[1]);
    end
  endtask

  task automatic test_backpressure();
    int nx, nd, fv;
    fill_random();
    run_stream(1, -1, 0, 0, -1, nx, nd, fv);
    check_full("pattern_ready_count", nx, nd);
    fill_random();
    run_stream(2, -1, 0, 0, -1, nx, nd, fv);
    check_full("random_ready_count", nx, nd);
  endtask

  task automatic test_restart_ignored();
    int nx, nd, fv;
    fill_random();
    run_stream(2, 3, 0, 0, -1, nx, nd, fv);
    check_full("restart_ignored", nx, nd);
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL restart_second_dump: busy=%b done=%b, required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_abort();
    int nx, nd, fv;
    fill_random();
    run_stream(0, -1, 40, 0, -1, nx, nd, fv);
    checks++;
    if (nx != 40 || nd != 0) begin
      errors++;
      $display("FAIL abort_count: transfers=%0d done_pulses=%0d, required 40 and 0", nx, nd);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    run_stream(2, -1, 0, 0, -1, nx, nd, fv);
    check_full("after_abort_full", nx, nd);
  endtask

  task automatic test_reset_mid();
    int nx, nd, fv;
    fill_random();
    run_stream(0, -1, 0, 0, 5, nx, nd, fv);
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_mid_done: done_pulses=%0d, required 0", nd);
    end
  endtask

  task automatic test_snapshot();
    int nx, nd, fv, v2;
    fill_random();
    v2 = int'($urandom_range(1, 100000));
    regs[2] = to_trits(v2);
    run_stream(2, -1, 0, 1, -1, nx, nd, fv);
    check_full("snapshot_count", nx, nd);
    checks++;
    if (cap_val[2] != longint'(v2)) begin
      errors++;
      $display("FAIL snapshot_r2: streamed R2 decodes to %0d, required pre-write %0d", cap_val[2], v2);
    end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_start_abort_ignored();
    test_r1_plus5();
    test_backpressure();
    test_restart_ignored();
    test_abort();
    test_reset_mid();
    test_snapshot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ternary_regdump.md
TERNARY_REGDUMP -- requirements
Module: ternary_regdump

Interface
REQ-001 SHALL have parameter NUM_REGS, default 9, number of registers scanned.
REQ-002 SHALL have parameter TRIT_WIDTH, default 27, trits per register.
REQ-003 SHALL have clk  input  1  clock, rising-edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start  input  1  dump request, sampled only in IDLE.
REQ-006 SHALL have abort  input  1  terminate dump, return to IDLE.
REQ-007 SHALL have dbg_reg_idx  output  4  register index driven to the register file debug port.
REQ-008 SHALL have dbg_reg_data  input  trit_t[TRIT_WIDTH]  combinational register contents for dbg_reg_idx.
REQ-009 SHALL have out_trit  output  trit_t  current serial trit.
REQ-010 SHALL have out_valid  output  1  out_trit valid.
REQ-011 SHALL have out_ready  input  1  sink accepts trit.
REQ-012 SHALL have out_reg_idx  output  4  register index of out_trit.
REQ-013 SHALL have out_last_trit  output  1  out_trit is trit 0 of its register.
REQ-014 SHALL have out_last  output  1  out_trit is the final trit of the dump.
REQ-015 SHALL have busy  output  1  high in any state except IDLE.
REQ-016 SHALL have done  output  1  one-cycle pulse on normal dump completion.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-018 IDLE: start=1 -> LOAD with reg counter = first index (0, or 1 per REQ-032); trit counter = TRIT_WIDTH-1.
REQ-019 LOAD: dbg_reg_idx = reg counter; dbg_reg_data captured into a shadow register at the clock edge; -> SHIFT; out_valid=0.
REQ-020 SHIFT: out_valid=1; out_trit = shadow[trit counter]; order MSB first (TRIT_WIDTH-1 down to 0).
REQ-021 A trit transfers only on out_valid&&out_ready; with out_ready=0, out_trit, out_reg_idx and flags SHALL hold stable.
REQ-022 On transfer with trit counter>0: trit counter decrements, state stays SHIFT.
REQ-023 On transfer of trit 0: if reg counter = NUM_REGS-1 -> DONE; else reg counter+1, trit counter reset, -> LOAD.
REQ-024 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-025 Dump latency: first out_valid two cycles after the start cycle; minimum per-register cost TRIT_WIDTH+1 cycles.
REQ-026 start outside IDLE SHALL be ignored; start with abort in the same IDLE cycle SHALL be ignored.
REQ-027 abort in LOAD/SHIFT/DONE -> IDLE next cycle, no done pulse; abort overrides a same-cycle transfer (the trit counts as delivered but no further state advance).
REQ-028 dbg_reg_idx SHALL hold its last value outside LOAD; contents of a register are snapshot at its LOAD cycle (later writes do not affect in-flight trits).
REQ-029 out_trit SHALL be T_ZERO whenever out_valid=0.

Reset
REQ-030 rst_n low SHALL force IDLE asynchronously, also mid-dump, with no done pulse.
REQ-031 Reset values: out_valid=0, out_trit=T_ZERO, dbg_reg_idx=0, out_reg_idx=0, out_last_trit=0, out_last=0, busy=0, done=0, shadow all T_ZERO.

Configuration
REQ-032 Macro REGDUMP_SKIP_R0_EN: defined -> scan starts at index 1, (NUM_REGS-1)*TRIT_WIDTH trits per dump; undefined -> starts at index 0, NUM_REGS*TRIT_WIDTH trits, R0 emitted as all T_ZERO.

Verification
REQ-033 R1=+5 (trits 2..0 = +,-,-, rest 0), out_ready=1, start pulse -> 243 transfers; reg 1 stream = 24 T_ZERO then +,-,-; out_last only on transfer 243; done one cycle after it (216 transfers, first out_reg_idx=1, with REGDUMP_SKIP_R0_EN).
REQ-034 out_ready toggled 1,0,0,1 pattern -> no trit lost or duplicated, values stable while out_ready=0, total count unchanged.
REQ-035 start asserted again during SHIFT of reg 3 -> ignored, single dump, single done.
REQ-036 abort at transfer 40 -> IDLE next cycle, busy=0, done never asserts; new start then yields full dump from first index.
REQ-037 rst_n low during reg 5 SHIFT -> all outputs at reset values immediately, dump not resumed after release.
REQ-038 R2 written to -1 after its LOAD cycle -> streamed reg 2 trits reflect pre-write value.
